// File: rtl/oam_dma_engine_if.sv
// CPU <-> MMU bus bundle seen by the OAM DMA engine.
// Signal names keep the DZCPU/MMU naming; i*/o* are relative to the engine.
//   master : the DMA engine (drives MMU side, returns data/wait to the CPU)
//   slave  : the environment (CPU drives i*Cpu*, MMU returns iMmuData)
interface oam_dma_engine_if;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic        iCpuWe;
  logic [7:0]  oCpuData;
  logic        oCpuWait;
  logic [15:0] oMmuAddr;
  logic [7:0]  oMmuData;
  logic        oMmuWe;
  logic [7:0]  iMmuData;

  modport master (
    input  iCpuAddr, iCpuData, iCpuWe, iMmuData,
    output oCpuData, oCpuWait, oMmuAddr, oMmuData, oMmuWe
  );

  modport slave (
    output iCpuAddr, iCpuData, iCpuWe, iMmuData,
    input  oCpuData, oCpuWait, oMmuAddr, oMmuData, oMmuWe
  );
endinterface

// File: rtl/oam_dma_engine.sv
// Game Boy OAM DMA engine. Sits between the CPU memory port and the MMU.
// A CPU write of XX to DMA_REG_ADDR copies XFER_LEN bytes from XX00.. to
// DST_BASE.., one READ + one WRITE cycle per byte, with the CPU stalled.
// Outside a transfer the MMU port is a combinational pass-through.
//
// Ports:
//   iClock, iReset : clock, asynchronous active-high reset
//   bus (master)   : CPU address/data/we in, read data/wait out; MMU addr/data/we out, data in
//   oDmaReg        : last value written to DMA_REG_ADDR
//   oDone          : one-cycle pulse in the WRITE cycle of the final byte
//
// Optional build macro PGB_DMA_SRC_CLAMP_EN: source pages >= E0 are read
// from page-20 (echo RAM mirrored onto WRAM). oDmaReg keeps the raw value.
module oam_dma_engine #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DST_BASE     = 16'hFE00,
  parameter int unsigned XFER_LEN     = 160
) (
  input  logic                    iClock,
  input  logic                    iReset,
  oam_dma_engine_if.master        bus,
  output logic [7:0]              oDmaReg,
  output logic                    oDone
);

  localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  dma_reg_q, dma_reg_d;
  logic [7:0]  src_page;
  logic        reg_hit;

  logic [15:0] mmu_addr;
  logic [7:0]  mmu_data;
  logic        mmu_we;
  logic [7:0]  cpu_data;
  logic        cpu_wait;
  logic        done;

`ifdef PGB_DMA_SRC_CLAMP_EN
  assign src_page = (dma_reg_q >= 8'hE0) ? (dma_reg_q - 8'h20) : dma_reg_q;
`else
  assign src_page = dma_reg_q;
`endif

  assign reg_hit = (bus.iCpuAddr == DMA_REG_ADDR);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dma_reg_d = dma_reg_q;
    mmu_addr  = bus.iCpuAddr;
    mmu_data  = bus.iCpuData;
    mmu_we    = bus.iCpuWe;
    cpu_data  = bus.iMmuData;
    cpu_wait  = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The DMA register lives here, not in the MMU: never forward it.
        if (reg_hit) begin
          mmu_we   = 1'b0;
          cpu_data = dma_reg_q;
          if (bus.iCpuWe) begin
            dma_reg_d = bus.iCpuData;
            cnt_d     = 8'h00;
            state_d   = StRead;
          end
        end
      end
      StRead: begin
        // Low byte never carries since XFER_LEN <= 256.
        mmu_addr = {src_page, 8'h00} + {8'h00, cnt_q};
        mmu_data = 8'h00;
        mmu_we   = 1'b0;
        cpu_data = 8'hFF;
        cpu_wait = 1'b1;
        state_d  = StWrite;
      end
      StWrite: begin
        // iMmuData holds the byte addressed in the preceding READ cycle.
        mmu_addr = DST_BASE + {8'h00, cnt_q};
        mmu_data = bus.iMmuData;
        mmu_we   = 1'b1;
        cpu_data = 8'hFF;
        cpu_wait = 1'b1;
        if (cnt_q == LastIdx) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_q + 8'h01;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase

    // Keep the MMU port quiet while reset is held, even though IDLE would
    // otherwise pass the CPU straight through.
    if (iReset) begin
      mmu_addr = 16'h0000;
      mmu_data = 8'h00;
      mmu_we   = 1'b0;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q   <= StIdle;
      cnt_q     <= 8'h00;
      dma_reg_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dma_reg_q <= dma_reg_d;
    end
  end

  assign bus.oMmuAddr = mmu_addr;
  assign bus.oMmuData = mmu_data;
  assign bus.oMmuWe   = mmu_we;
  assign bus.oCpuData = cpu_data;
  assign bus.oCpuWait = cpu_wait;
  assign oDmaReg      = dma_reg_q;
  assign oDone        = done;

endmodule

// File: tb/tb_oam_dma_engine.sv
module tb_oam_dma_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dma_reg;
  logic       done;

  oam_dma_engine_if bus ();

  oam_dma_engine #(
    .DMA_REG_ADDR (16'hFF46),
    .DST_BASE     (16'hFE00),
    .XFER_LEN     (160)
  ) dut (
    .iClock  (clk),
    .iReset  (rst),
    .bus     (bus),
    .oDmaReg (dma_reg),
    .oDone   (done)
  );

  always #5 clk = ~clk;

  // MMU model: synchronous write, read data valid the cycle after the address.
  logic [7:0] mem [65536] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.oMmuWe) mem[bus.oMmuAddr] <= bus.oMmuData;
    bus.iMmuData <= mem[bus.oMmuAddr];
  end

  // Bench-side memory image, updated only from stimulus and expectations.
  logic [7:0] model [65536] = '{default: 8'h00};

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every DMA write to the MMU must match the next expectation.
  always @(negedge clk) begin
    if (!rst && bus.oCpuWait && bus.oMmuWe) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", {16'h0, bus.oMmuAddr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        model[e.addr] = e.data;
        chk("sb_addr", {16'h0, bus.oMmuAddr}, {16'h0, e.addr});
        chk("sb_data", {24'h0, bus.oMmuData}, {24'h0, e.data});
      end
    end
    if (!rst && done) done_cnt++;
  end

  function automatic logic [7:0] src_page(input logic [7:0] p);
`ifdef PGB_DMA_SRC_CLAMP_EN
    return (p >= 8'hE0) ? p - 8'h20 : p;
`else
    return p;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.iCpuAddr = a;
    bus.iCpuData = d;
    bus.iCpuWe   = 1'b1;
    if (!bus.oCpuWait && a != 16'hFF46) model[a] = d;
    step();
    bus.iCpuWe = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    bus.iCpuAddr = a;
    bus.iCpuWe   = 1'b0;
    step();
    d = bus.oCpuData;
  endtask

  task automatic trigger(input logic [7:0] page);
    bus.iCpuAddr = 16'hFF46;
    bus.iCpuData = page;
    bus.iCpuWe   = 1'b1;
    #1;
    chk("ff46_no_mmu_we", {31'h0, bus.oMmuWe}, 32'h0);
    for (int i = 0; i < 160; i++) begin
      exp_t e;
      e.addr = 16'hFE00 + 16'(i);
      e.data = model[{src_page(page), 8'h00} + 16'(i)];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.iCpuWe = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.oCpuWait && n < 1000) begin
      n++;
      step();
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [7:0]  exp_rd;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    logic [7:0] d;
    int n;
    int d0;

    vecs[0] = '{addr: 16'h8000, data: 8'h3C, we: 1'b1, exp_rd: 8'h00};
    vecs[1] = '{addr: 16'h9ABC, data: 8'hA5, we: 1'b1, exp_rd: 8'h00};
    vecs[2] = '{addr: 16'hC123, data: 8'h0F, we: 1'b1, exp_rd: 8'h00};
    vecs[3] = '{addr: 16'h8000, data: 8'h00, we: 1'b0, exp_rd: 8'h3C};
    vecs[4] = '{addr: 16'h9ABC, data: 8'h00, we: 1'b0, exp_rd: 8'hA5};
    vecs[5] = '{addr: 16'hFF46, data: 8'h00, we: 1'b0, exp_rd: 8'h00};

    rst          = 1'b1;
    bus.iCpuAddr = 16'h1234;
    bus.iCpuData = 8'h99;
    bus.iCpuWe   = 1'b1;
    #1;
    chk("rst_wait", {31'h0, bus.oCpuWait}, 32'h0);
    chk("rst_mmu_we", {31'h0, bus.oMmuWe}, 32'h0);
    chk("rst_mmu_addr", {16'h0, bus.oMmuAddr}, 32'h0);
    chk("rst_mmu_data", {24'h0, bus.oMmuData}, 32'h0);
    chk("rst_dma_reg", {24'h0, dma_reg}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    bus.iCpuWe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Pass-through vectors.
    foreach (vecs[k]) begin
      bus.iCpuAddr = vecs[k].addr;
      bus.iCpuData = vecs[k].data;
      bus.iCpuWe   = vecs[k].we;
      if (vecs[k].we && vecs[k].addr != 16'hFF46) model[vecs[k].addr] = vecs[k].data;
      #1;
      chk($sformatf("pt_addr[%0d]", k), {16'h0, bus.oMmuAddr}, {16'h0, vecs[k].addr});
      chk($sformatf("pt_data[%0d]", k), {24'h0, bus.oMmuData}, {24'h0, vecs[k].data});
      chk($sformatf("pt_we[%0d]", k), {31'h0, bus.oMmuWe}, {31'h0, vecs[k].we});
      step();
      bus.iCpuWe = 1'b0;
      if (!vecs[k].we) chk($sformatf("pt_rd[%0d]", k), {24'h0, bus.oCpuData},
                           {24'h0, vecs[k].exp_rd});
    end

    // Preload source page C0 and a known OAM background.
    for (int i = 0; i < 160; i++) cpu_write(16'hC000 + 16'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < 160; i++) cpu_write(16'hFE00 + 16'(i), 8'hEE);

    // Reset at byte 50.
    trigger(8'hC0);
    repeat (100) step();
    chk("mid_pops", pops, 50);
    rst = 1'b1;
    #1;
    chk("mid_rst_wait", {31'h0, bus.oCpuWait}, 32'h0);
    chk("mid_rst_mmu_we", {31'h0, bus.oMmuWe}, 32'h0);
    chk("mid_rst_dma_reg", {24'h0, dma_reg}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    sb.delete();
    step();
    rst = 1'b0;
    chk("mid_no_done", done_cnt, 0);
    cpu_read(16'hFE31, d);
    chk("mid_fe31", {24'h0, d}, {24'h0, 8'h31 ^ 8'h5A});
    for (int i = 16'h32; i < 160; i++) begin
      cpu_read(16'hFE00 + 16'(i), d);
      chk($sformatf("mid_untouched[%0h]", i), {24'h0, d}, 32'hEE);
    end

    // Full copy.
    d0   = done_cnt;
    pops = 0;
    trigger(8'hC0);
    wait_idle(n);
    chk("copy_wait_cycles", n, 320);
    chk("copy_done_pulses", done_cnt - d0, 1);
    chk("copy_pops", pops, 160);
    chk("copy_sb_empty", sb.size(), 0);
    for (int i = 0; i < 160; i++) begin
      cpu_read(16'hFE00 + 16'(i), d);
      chk($sformatf("copy_oam[%0h]", i), {24'h0, d}, {24'h0, 8'(i) ^ 8'h5A});
    end
    cpu_read(16'hFF46, d);
    chk("copy_ff46", {24'h0, d}, 32'hC0);

    // Back-to-back trigger with CPU activity blocked during the copy.
    trigger(8'hC0);
    repeat (3) step();
    cpu_write(16'hFF46, 8'h77);
    cpu_write(16'h8000, 8'h11);
    cpu_read(16'hFF46, d);
    chk("blk_rd_ff46", {24'h0, d}, 32'hFF);
    cpu_read(16'h8000, d);
    chk("blk_rd_8000", {24'h0, d}, 32'hFF);
    chk("blk_wait_high", {31'h0, bus.oCpuWait}, 32'h1);
    wait_idle(n);
    chk("blk_finished", {31'h0, bus.oCpuWait}, 32'h0);
    chk("blk_dma_reg", {24'h0, dma_reg}, 32'hC0);
    cpu_read(16'h8000, d);
    chk("blk_8000_kept", {24'h0, d}, 32'h3C);

    // Echo-RAM source page.
    cpu_write(16'hC100, 8'hAB);
    cpu_write(16'hE100, 8'h5D);
    trigger(8'hE1);
    wait_idle(n);
    chk("clamp_cycles", n, 320);
    cpu_read(16'hFE00, d);
`ifdef PGB_DMA_SRC_CLAMP_EN
    chk("clamp_fe00", {24'h0, d}, 32'hAB);
`else
    chk("clamp_fe00", {24'h0, d}, 32'h5D);
`endif
    chk("clamp_dma_reg", {24'h0, dma_reg}, 32'hE1);
    chk("clamp_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_engine.md
Name: oam_dma_engine

Overview:
- Game Boy OAM DMA controller between the DZCPU memory port (oMCUAddr/oMCUData/iMCUData/write-enable) and the MMU.
- A CPU write to register 0xFF46 with value XX copies 160 bytes from XX00..XX9F to OAM at FE00..FE9F.
- During the copy the engine owns the MMU port and holds the CPU in a wait state.
- Outside a transfer it is a transparent pass-through.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU address of the DMA trigger/source register.
- DST_BASE, 16'hFE00, OAM base destination address.
- XFER_LEN, 160, bytes per transfer (1..256).

Ports:
- iClock  in  1  system clock.
- iReset  in  1  asynchronous, active-high reset.
- iCpuAddr  in  16  CPU address (oMCUAddr of DZCPU).
- iCpuData  in  8  CPU write data.
- iCpuWe  in  1  CPU write enable.
- oCpuData  out  8  read data returned to CPU (to iMCUData).
- oCpuWait  out  1  1 = CPU must stall; high for the whole transfer.
- oMmuAddr  out  16  address to MMU.
- oMmuData  out  8  write data to MMU.
- oMmuWe  out  1  MMU write enable.
- iMmuData  in  8  MMU read data; valid the cycle after the address is presented.
- oDmaReg  out  8  last value written to DMA_REG_ADDR.
- oDone  out  1  one-cycle pulse when the final byte is written.

Behaviour:
- Reset (async, iReset=1): state IDLE, byte counter 0, oDmaReg=8'h00, oCpuWait=0, oDone=0, oMmuWe=0, oMmuAddr=16'h0000, oMmuData=8'h00.
- States: IDLE, READ, WRITE.
- IDLE:
  - MMU port driven combinationally from the CPU: oMmuAddr=iCpuAddr, oMmuData=iCpuData, oMmuWe=iCpuWe, oCpuData=iMmuData.
  - Exception: CPU access to DMA_REG_ADDR is not forwarded. oMmuWe=0 for that write, and a read returns oDmaReg.
- Trigger: in IDLE, iCpuWe=1 with iCpuAddr==DMA_REG_ADDR registers oDmaReg<=iCpuData, counter<=0, next state READ. The transfer starts on the following edge.
- READ:
  - oMmuAddr={oDmaReg,8'h00}+counter, oMmuWe=0, oCpuWait=1.
  - Always goes to WRITE.
- WRITE:
  - oMmuAddr=DST_BASE+counter, oMmuData=iMmuData (combinational, data of the preceding READ), oMmuWe=1, oCpuWait=1.
  - If counter==XFER_LEN-1: go to IDLE and pulse oDone in this WRITE cycle.
  - Otherwise counter+1 and go to READ.
- Latency: 2 cycles per byte. A transfer occupies exactly 2*XFER_LEN cycles (320 by default) after the trigger cycle. oCpuWait is high for exactly those cycles.
- Address arithmetic is 16-bit. The low byte never carries because XFER_LEN<=256, so a source of FF00+n stays within page FF.
- While oCpuWait=1:
  - CPU writes (including to DMA_REG_ADDR) are ignored.
  - oCpuData=8'hFF.
  - No retrigger is possible.
- A trigger write in the same cycle as oDone is impossible, because the CPU is still waiting.
- Reset mid-transfer: immediate return to IDLE. The partial OAM contents are left as written, oCpuWait drops asynchronously, and no oDone is issued.
- oDmaReg persists after a transfer. Back-to-back triggers are allowed from the first IDLE cycle.

Optional Feature:
- Macro PGB_DMA_SRC_CLAMP_EN.
- Defined: a source page value >= 8'hE0 is mapped to page-8'h20 when forming the READ address, which mirrors echo RAM to WRAM. For example, a write of E1 reads C100..C19F. oDmaReg still reports the raw written value.
- Undefined: the source page is used verbatim (E1 reads E100..E19F).

Test Plan:
- Reset values: assert iReset mid-simulation -> oCpuWait=0, oMmuWe=0, oDmaReg=00, oDone=0 immediately, without waiting for a clock edge.
- Basic copy: preload C000..C09F with i^8'h5A; CPU writes C0 to FF46 -> oCpuWait high for exactly 320 cycles, FE00..FE9F equal i^8'h5A, a single oDone pulse, FF46 reads C0.
- Pass-through: in IDLE, CPU write 8'h3C to 8000 and read it back -> MMU sees the same address, data and write enable in the same cycle, and the read returns 3C. A write to FF46 never asserts oMmuWe.
- Blocking: during a transfer, CPU writes 8'h77 to FF46 and 8'h11 to 8000, and reads FF46 -> oDmaReg unchanged, 8000 unchanged, CPU reads return FF.
- Reset mid-transfer: reset at byte 50 -> FE00..FE31 copied, FE32..FE9F untouched, no oDone. A new trigger afterwards completes normally.
- Clamp: trigger with E1 and C100 preloaded with 8'hAB -> FE00=AB with PGB_DMA_SRC_CLAMP_EN defined; FE00 equals MMU[E100] without it.
